// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: field positions, node address type and the
// packed packet layout {dest, src, payload}.
package noc_pkg;

  localparam int WIDTH_PACKAGE = 33;
  localparam int DEST_MSB      = 32;
  localparam int DEST_LSB      = 29;
  localparam int SRC_MSB       = 28;
  localparam int SRC_LSB       = 25;
  localparam int PAYLOAD_W     = 25;

  typedef logic [3:0] node_addr_t;

  typedef struct packed {
    node_addr_t           dest;
    node_addr_t           src;
    logic [PAYLOAD_W-1:0] payload;
  } noc_pkt_t;

  typedef enum logic {
    T_IDLE,
    T_WAIT_ACK
  } tx_state_t;

endpackage

// File: rtl/noc_rx_fifo.sv
// Receive FIFO for the NoC endpoint: power-of-two depth, head word presented
// combinationally, pushes while full and pops while empty are ignored.
module noc_rx_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 29
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pe_noc_endpoint.sv
// NoC endpoint: 2-phase bundled-data TX/RX toward one router port, valid/ready
// toward the PE. Optional misroute filtering under PE_NOC_DEST_CHECK_EN.
import noc_pkg::*;

module pe_noc_endpoint #(
  parameter int         WIDTH_PACKAGE = 33,
  parameter node_addr_t NODE_LOC      = 4'b00_00,
  parameter int         RX_DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     tx_req,
  output logic [WIDTH_PACKAGE-1:0] tx_data,
  input  logic                     tx_ack,
  input  logic                     rx_req,
  input  logic [WIDTH_PACKAGE-1:0] rx_data,
  output logic                     rx_ack,
  input  logic                     send_valid,
  output logic                     send_ready,
  input  logic [3:0]               send_dest,
  input  logic [PAYLOAD_W-1:0]     send_payload,
  output logic                     recv_valid,
  input  logic                     recv_ready,
  output logic [3:0]               recv_src,
  output logic [PAYLOAD_W-1:0]     recv_payload,
  output logic [7:0]               misroute_count
);

  tx_state_t state_reg, state_next;
  logic      tx_ack_meta_reg, tx_ack_sync_reg;
  logic      rx_req_meta_reg, rx_req_sync_reg;
  logic      tx_req_reg, rx_ack_reg;
  noc_pkt_t  tx_data_reg;
  noc_pkt_t  tx_pkt, rx_pkt;
  logic      send_fire, rx_pending, rx_push, rx_ack_toggle;
  logic      fifo_full, fifo_empty;
  logic [SRC_MSB-SRC_LSB+PAYLOAD_W:0] head_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ack_meta_reg <= 1'b0;
      tx_ack_sync_reg <= 1'b0;
      rx_req_meta_reg <= 1'b0;
      rx_req_sync_reg <= 1'b0;
    end else begin
      tx_ack_meta_reg <= tx_ack;
      tx_ack_sync_reg <= tx_ack_meta_reg;
      rx_req_meta_reg <= rx_req;
      rx_req_sync_reg <= rx_req_meta_reg;
    end
  end

  assign tx_pkt    = '{dest: send_dest, src: NODE_LOC, payload: send_payload};
  assign send_fire = send_valid & send_ready;

  always_comb begin
    state_next = state_reg;
    send_ready = 1'b0;
    case (state_reg)
      T_IDLE: begin
        send_ready = 1'b1;
        if (send_valid) state_next = T_WAIT_ACK;
      end
      T_WAIT_ACK: begin
        if (tx_ack_sync_reg == tx_req_reg) state_next = T_IDLE;
      end
      default: state_next = T_IDLE;
    endcase
  end

  // tx_data only loads on an accept, so it holds for the whole handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= T_IDLE;
      tx_req_reg  <= 1'b0;
      tx_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (send_fire) begin
        tx_req_reg  <= ~tx_req_reg;
        tx_data_reg <= tx_pkt;
      end
    end
  end

  assign tx_req     = tx_req_reg;
  assign tx_data    = tx_data_reg;
  assign rx_pkt     = rx_data;
  assign rx_pending = (rx_req_sync_reg != rx_ack_reg);

`ifdef PE_NOC_DEST_CHECK_EN
  logic       misroute;
  logic [7:0] misroute_cnt_reg;

  assign misroute      = rx_pending && (rx_pkt.dest != NODE_LOC);
  assign rx_push       = rx_pending & ~misroute & ~fifo_full;
  assign rx_ack_toggle = rx_push | misroute;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misroute_cnt_reg <= 8'd0;
    end else if (misroute && misroute_cnt_reg != 8'hFF) begin
      misroute_cnt_reg <= misroute_cnt_reg + 8'd1;
    end
  end

  assign misroute_count = misroute_cnt_reg;
`else
  logic unused_dest;

  assign unused_dest    = ^rx_pkt.dest;
  assign rx_push        = rx_pending & ~fifo_full;
  assign rx_ack_toggle  = rx_push;
  assign misroute_count = 8'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ack_reg <= 1'b0;
    end else if (rx_ack_toggle) begin
      rx_ack_reg <= ~rx_ack_reg;
    end
  end

  assign rx_ack = rx_ack_reg;

  noc_rx_fifo #(
    .DEPTH  (RX_DEPTH),
    .DATA_W (SRC_MSB - SRC_LSB + 1 + PAYLOAD_W)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data ({rx_pkt.src, rx_pkt.payload}),
    .pop       (recv_valid & recv_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head_data)
  );

  assign recv_valid   = ~fifo_empty;
  assign recv_src     = head_data[PAYLOAD_W+3:PAYLOAD_W];
  assign recv_payload = head_data[PAYLOAD_W-1:0];

endmodule
